// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
// Lane functions assume little-endian byte order within a 32-bit word.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RDWAIT = 3'd2,
        WR     = 3'd3,
        RESP   = 3'd4,
        ERR    = 3'd5
    } lsu_state_t;

    function automatic logic [31:0] lane_extract(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
            SZ_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Only the addressed lane(s) take store data; the rest keep the old word.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] word,
        input logic [1:0]  lo,
        input logic [1:0]  size,
        input logic [31:0] wdata
    );
        logic [31:0] m;
        m = word;
        case (size)
            SZ_BYTE: m[{lo, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lo[1]) m[31:16] = wdata[15:0];
                else       m[15:0]  = wdata[15:0];
            end
            default: m = wdata;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Combinational lane alignment: load extraction/extension and store merge
// of a read-back memory word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    always_comb begin
        load_val = lane_extract(word, addr_lo, size, is_unsigned);
        merged   = lane_merge(word, addr_lo, size, wdata);
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-only memory; one request
// in flight, read-modify-write for sub-word stores.
//
// Handshake: a request transfers on a rising clk edge where req_valid and
// req_ready are both 1; req_ready is 1 only in IDLE. resp_valid is a
// one-cycle pulse with no backpressure, qualified by resp_err.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data,
    output logic        mem_memW,
    output logic        mem_memR,
    input  logic [31:0] mem_readData,
    output lsu_state_t  dbg_state
);

    lsu_state_t  state;
    logic [31:0] addr_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf;
    logic        req_bad;
    logic [31:0] load_val;
    logic [31:0] merged;

    always_comb begin
        req_bad = (req_size == SZ_RSVD)
               || (req_size == SZ_HALF && req_addr[0])
               || (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
               || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    end

    lsu_lane_align u_align (
        .word        (mem_readData),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       (wdata_q),
        .load_val    (load_val),
        .merged      (merged)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            wbuf       <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        size_q  <= req_size;
                        uns_q   <= req_unsigned;
                        wdata_q <= req_wdata;
                        wbuf    <= req_wdata;
                        if (req_bad) begin
                            state      <= ERR;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && req_size == SZ_WORD) begin
                            state <= WR;
                        end else begin
                            state <= RD;
                        end
                    end
                end
                RD: state <= RDWAIT;
                // Memory data is valid here, one cycle after the read strobe.
                RDWAIT: begin
                    if (we_q) begin
                        wbuf  <= merged;
                        state <= WR;
                    end else begin
                        resp_valid <= 1'b1;
                        resp_rdata <= load_val;
                        state      <= RESP;
                    end
                end
                WR: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    state      <= RESP;
                end
                RESP:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state == IDLE);
    assign mem_memR    = (state == RD);
    assign mem_memW    = (state == WR);
    assign mem_address = {2'b00, addr_q[31:2]};
    assign mem_data    = wbuf;
    assign dbg_state   = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a behavioural
// word memory (read data registered one cycle after mem_memR).
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = SZ_WORD;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address;
    logic [31:0] mem_data;
    logic        mem_memW;
    logic        mem_memR;
    logic [31:0] mem_readData = '0;
    lsu_state_t  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_memW     (mem_memW),
        .mem_memR     (mem_memR),
        .mem_readData (mem_readData),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Memory model and monitors
    logic [31:0] mem [MEM_WORDS];
    int cyc = 0;
    int memw_cnt = 0;
    int memr_cnt = 0;
    int both_cnt = 0;
    int resp_cnt = 0;
    int acc_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else begin
            if (mem_memR) mem_readData <= mem[mem_address[4:0]];
            if (mem_memW) mem[mem_address[4:0]] <= mem_data;
        end
        if (mem_memW) memw_cnt <= memw_cnt + 1;
        if (mem_memR) memr_cnt <= memr_cnt + 1;
        if (mem_memW && mem_memR) both_cnt <= both_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
        if (!reset && req_valid && req_ready) acc_q.push_back(cyc);
    end

    // One request; lat counts edges from handshake to the response cycle (0 = timeout).
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic err, output logic [31:0] rdata,
                          output logic next_valid);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        lat = 0; err = 1'b0; rdata = '0; next_valid = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = i; err = resp_err; rdata = resp_rdata;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            next_valid = resp_valid;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00000000",
                     req_ready, resp_valid, resp_err, resp_rdata);
        end
        n_checks++;
        if (mem_memW !== 1'b0 || mem_memR !== 1'b0 || mem_address !== 32'h0 || mem_data !== 32'h0
            || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mem: W=%b R=%b addr=%h data=%h state=%0d, required 0 0 0 0 IDLE",
                     mem_memW, mem_memR, mem_address, mem_data, dbg_state);
        end
        reset = 1'b0;
    endtask

    task automatic test_word();
        int lat; logic err; logic [31:0] rd; logic nv; int w0;
        w0 = memw_cnt;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, lat, err, rd, nv);
        n_checks++;
        if (lat !== 2 || err !== 1'b0 || rd !== 32'h0 || nv !== 1'b0) begin
            n_fail++;
            $display("FAIL word_store_resp: lat=%0d err=%b rdata=%h next=%b, required 2 0 00000000 0",
                     lat, err, rd, nv);
        end
        n_checks++;
        if (mem[4] !== 32'hDEADBEEF || memw_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL word_store_mem: mem4=%h writes=%0d, required DEADBEEF 1", mem[4], memw_cnt - w0);
        end
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL word_load: lat=%0d err=%b rdata=%h, required 3 0 DEADBEEF", lat, err, rd);
        end
    endtask

    task automatic test_byte();
        int lat; logic err; logic [31:0] rd; logic nv; int w0;
        w0 = memw_cnt;
        do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'h123456AA, lat, err, rd, nv);
        n_checks++;
        if (lat !== 4 || err !== 1'b0 || mem[4] !== 32'hDEADAAEF || memw_cnt - w0 !== 1) begin
            n_fail++;
            $display("FAIL byte_store: lat=%0d err=%b mem4=%h writes=%0d, required 4 0 DEADAAEF 1",
                     lat, err, mem[4], memw_cnt - w0);
        end
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 3 || rd !== 32'hFFFFFFAA) begin
            n_fail++;
            $display("FAIL byte_load_signed: lat=%0d rdata=%h, required 3 FFFFFFAA", lat, rd);
        end
        do_req(1'b0, SZ_BYTE, 1'b1, 32'h11, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 3 || rd !== 32'h000000AA) begin
            n_fail++;
            $display("FAIL byte_load_unsigned: lat=%0d rdata=%h, required 3 000000AA", lat, rd);
        end
        do_req(1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (rd !== 32'hFFFFFFDE) begin
            n_fail++;
            $display("FAIL byte_load_lane3: rdata=%h, required FFFFFFDE", rd);
        end
    endtask

    task automatic test_half();
        int lat; logic err; logic [31:0] rd; logic nv; int r0;
        do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h80011234, lat, err, rd, nv);
        do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'hFFFF8001) begin
            n_fail++;
            $display("FAIL half_load_signed: lat=%0d err=%b rdata=%h, required 3 0 FFFF8001", lat, err, rd);
        end
        do_req(1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (rd !== 32'h00001234) begin
            n_fail++;
            $display("FAIL half_load_unsigned: rdata=%h, required 00001234", rd);
        end
        do_req(1'b1, SZ_HALF, 1'b0, 32'h10, 32'hABCD5678, lat, err, rd, nv);
        n_checks++;
        if (lat !== 4 || mem[4] !== 32'h80015678) begin
            n_fail++;
            $display("FAIL half_store: lat=%0d mem4=%h, required 4 80015678", lat, mem[4]);
        end
        r0 = memr_cnt;
        do_req(1'b0, SZ_HALF, 1'b0, 32'h13, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || memr_cnt !== r0 || nv !== 1'b0) begin
            n_fail++;
            $display("FAIL half_misaligned: lat=%0d err=%b rdata=%h reads=%0d next=%b, required 1 1 0 0 0",
                     lat, err, rd, memr_cnt - r0, nv);
        end
    endtask

    task automatic test_errors();
        int lat; logic err; logic [31:0] rd; logic nv; int r0; int w0;
        do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, err, rd, nv);
        r0 = memr_cnt; w0 = memw_cnt;
        do_req(1'b0, SZ_WORD, 1'b0, 32'(MEM_WORDS * 4), 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL out_of_range: lat=%0d err=%b rdata=%h, required 1 1 00000000", lat, err, rd);
        end
        do_req(1'b0, SZ_RSVD, 1'b0, 32'h0, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 1 || err !== 1'b1 || rd !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_size: lat=%0d err=%b rdata=%h, required 1 1 00000000", lat, err, rd);
        end
        do_req(1'b1, SZ_WORD, 1'b0, 32'h12, 32'h55555555, lat, err, rd, nv);
        n_checks++;
        if (err !== 1'b1 || mem[4] !== 32'h80015678 || memr_cnt !== r0 || memw_cnt !== w0) begin
            n_fail++;
            $display("FAIL err_no_access: err=%b mem4=%h reads=%0d writes=%0d, required 1 80015678 0 0",
                     err, mem[4], memr_cnt - r0, memw_cnt - w0);
        end
        do_req(1'b1, SZ_WORD, 1'b0, 32'h7C, 32'h5A5A5A5A, lat, err, rd, nv);
        do_req(1'b0, SZ_WORD, 1'b0, 32'h7C, 32'h0, lat, err, rd, nv);
        n_checks++;
        if (lat !== 3 || err !== 1'b0 || rd !== 32'h5A5A5A5A || mem[31] !== 32'h5A5A5A5A) begin
            n_fail++;
            $display("FAIL last_word: lat=%0d err=%b rdata=%h mem31=%h, required 3 0 5A5A5A5A 5A5A5A5A",
                     lat, err, rd, mem[31]);
        end
    endtask

    task automatic test_reset_midop();
        int w0; int v0; logic [31:0] m4;
        w0 = memw_cnt; v0 = resp_cnt; m4 = mem[4];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_unsigned = 1'b0;
        req_addr = 32'h11; req_wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_midop_ready: ready=%b state=%0d, required 1 IDLE", req_ready, dbg_state);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (memw_cnt !== w0 || resp_cnt !== v0 || mem[4] !== m4) begin
            n_fail++;
            $display("FAIL reset_midop_drop: writes=%0d resps=%0d mem4=%h, required 0 0 %h",
                     memw_cnt - w0, resp_cnt - v0, mem[4], m4);
        end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h11111111;
        repeat (4) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (acc_q.size() !== 2) begin
            n_fail++;
            $display("FAIL b2b_accepts: count=%0d, required 2", acc_q.size());
        end else if (acc_q[1] - acc_q[0] !== 3) begin
            n_fail++;
            $display("FAIL b2b_accepts: interval=%0d, required 3", acc_q[1] - acc_q[0]);
        end
        n_checks++;
        if (both_cnt !== 0 || mem[8] !== 32'h11111111) begin
            n_fail++;
            $display("FAIL b2b_mem: both_high=%0d mem8=%h, required 0 11111111", both_cnt, mem[8]);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
